spi_receiver: RTL and testbench
===============================

# spi_receiver

Oversampling SPI slave receiver and the receive-side counterpart of `spi_transmitter`. It synchronizes externally generated `ss`, `sclk` and `sdi` into the system `clock` domain and detects sampling edges there. It assembles `bitcount`-bit words and presents each completed word with a one-cycle `valid` pulse. It sits between an SPI pin group and on-chip consumers such as register banks and DAC/ADC shims.

## Interface
- `bitcount`, 16: bits per frame; 2..64.
- `ss_polarity`, 0: 0 = active-low `ss`, 1 = active-high.
- `sclk_polarity`, 1: CPOL, the idle level of `sclk`.
- `sclk_phase`, 1: CPHA; 0 = sample on leading edge, 1 = sample on trailing edge.
- `msb_first`, 1: 1 = first received bit lands in `data[bitcount-1]`; 0 = in `data[0]`.
- `sync_stages`, 2: flip-flop depth of the input synchronizers; 2..4.

- `clock`  in  1  system clock; must be ≥ 4× the `sclk` frequency.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ss`  in  1  slave select, asynchronous.
- `sclk`  in  1  serial clock, asynchronous.
- `sdi`  in  1  serial data in, asynchronous.
- `data`  out  `bitcount`  last completed word; holds its value until the next completed frame.
- `valid`  out  1  one-cycle pulse when `data` updates.
- `busy`  out  1  high while a frame is selected (state ≠ IDLE).
- `frame_error`  out  1  one-cycle pulse on a short or long frame; present only with the macro (see Configuration).

## Operation
- Normalization after synchronization:
  - `ss_i` is active-high.
  - `sclk_i` is CPOL-0.
  - Sample edge is rising `sclk_i` when CPHA=0, falling when CPHA=1.
- Edge detection compares the synchronized value with a one-cycle-delayed copy; one detected edge = one clock-wide strobe.
- FSM states:
  - IDLE → ACTIVE on `ss_i` rising; clears the shift register and bit counter.
  - ACTIVE: on each sample strobe, shift the synchronized `sdi` in (direction per `msb_first`) and increment the counter (width `$clog2(bitcount+1)`).
    - When the counter reaches `bitcount`: `data` ← shift register, `valid` pulses, go to FULL.
  - FULL: further sample strobes are counted as overflow and no data is shifted.
  - ACTIVE or FULL → IDLE on `ss_i` falling; no new `data` is produced.
- One word per `ss` assertion; back-to-back frames require `ss` to deassert between them.
- CPHA=1: the leading edge of the first bit is ignored; only trailing edges sample.
- Deselect mid-frame (counter < `bitcount`): the partial word is discarded and `data` is unchanged.
- Simultaneous sample strobe and `ss_i` fall in the same cycle: deselect wins and the strobe is dropped.
- Reset values: `data`=0, `valid`=0, `busy`=0, `frame_error`=0, state IDLE, all synchronizer stages 0 (inactive after normalization).
- Reset asserted mid-frame: returns to IDLE immediately; the partial word is lost.

## Timing
- Input to internal signal: `sync_stages` clocks; edge strobe 1 clock later.
- `valid` asserts on the clock after the final sample strobe, i.e. `sync_stages`+2 clocks after the pin edge. `data` is stable in the same cycle and holds afterwards.
- `busy` rises `sync_stages`+1 clocks after the `ss` pin asserts and falls the same delay after it deasserts.
- `sdi` must be stable for ≥ 2 `clock` periods around each sampling edge.

## Configuration
- Macro: `SPI_RECEIVER_FRAME_ERROR_EN`.
- Defined:
  - `frame_error` port exists.
  - It pulses for one cycle on `ss_i` falling if the counter < `bitcount` (short frame).
  - It also pulses on `ss_i` falling if any overflow strobe occurred in FULL (long frame).
  - Overflow is tracked with a 1-bit sticky flag cleared on entry to ACTIVE.
- Undefined: no port, no overflow flag; short and long frames are silently handled as described in Operation.

## Structure
- Shared package `spi_pkg`:
  - FSM state enum `spi_rx_state_t` (IDLE, ACTIVE, FULL).
  - Constants `SPI_SYNC_MIN`=2 and `SPI_SYNC_MAX`=4.
  - Polarity/phase encoding constants, also used by `spi_transmitter`.
- Sub-module `spi_input_synchronizer`:
  - N-stage synchronizer plus rise/fall strobe outputs.
  - Instantiated three times (`ss`, `sclk`, `sdi`; edge outputs unused for `sdi`).

## Test plan
- Mode 3 (defaults), MSB first, `sclk` = `clock`/8, send 0xA5C3 → one `valid` pulse, `data`=0xA5C3, `busy` low `sync_stages`+1 clocks after `ss` rises.
- Mode 0, `msb_first`=0, `bitcount`=8, send bit stream 1,0,0,0,0,0,0,0 → `data`=0x01.
- Deselect after 9 of 16 bits, with `data` previously 0x1234 → no `valid`, `data` stays 0x1234; with macro, `frame_error` pulses once.
- 18 clocks within one `ss` frame carrying 0xBEEF then 2 extra bits → `data`=0xBEEF, one `valid`; with macro, `frame_error` on deselect.
- Assert `reset_n`=0 mid-frame after 5 bits, release, then send a full 0x0F0F frame → all outputs 0 during reset, then `data`=0x0F0F.
- Two back-to-back frames 0x1111 and 0x2222 with a 3-clock `ss` gap → two `valid` pulses carrying those values in order.

Source files
------------

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI types and encodings for spi_receiver and spi_transmitter
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        FULL
    } spi_rx_state_t;

    localparam int SPI_SYNC_MIN = 2;
    localparam int SPI_SYNC_MAX = 4;

    localparam bit SPI_SS_ACTIVE_LOW  = 1'b0;
    localparam bit SPI_SS_ACTIVE_HIGH = 1'b1;
    localparam bit SPI_CPOL_IDLE_LOW  = 1'b0;
    localparam bit SPI_CPOL_IDLE_HIGH = 1'b1;
    localparam bit SPI_CPHA_LEADING   = 1'b0;
    localparam bit SPI_CPHA_TRAILING  = 1'b1;

endpackage

// File: rtl/spi_input_synchronizer.sv
// rtl/spi_input_synchronizer.sv - N-stage synchronizer with polarity normalization and edge strobes
module spi_input_synchronizer #(
    parameter int stages = 2,
    parameter bit invert = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [stages-1:0] sync_q;
    logic              prev_q;

    // Inversion is a static constant, so applying it ahead of the first flop
    // lets every stage reset to the normalized inactive level of 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[stages-2:0], din ^ invert};
            prev_q <= sync_q[stages-1];
        end
    end

    assign dout = sync_q[stages-1];
    assign rise = dout & ~prev_q;
    assign fall = ~dout & prev_q;

endmodule

// File: rtl/spi_receiver.sv
// rtl/spi_receiver.sv - oversampling SPI slave receiver; optional SPI_RECEIVER_FRAME_ERROR_EN adds frame_error
module spi_receiver
    import spi_pkg::*;
#(
    parameter int unsigned bitcount      = 16,
    parameter bit          ss_polarity   = SPI_SS_ACTIVE_LOW,
    parameter bit          sclk_polarity = SPI_CPOL_IDLE_HIGH,
    parameter bit          sclk_phase    = SPI_CPHA_TRAILING,
    parameter bit          msb_first     = 1'b1,
    parameter int          sync_stages   = 2
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                ss,
    input  logic                sclk,
    input  logic                sdi,
    output logic [bitcount-1:0] data,
    output logic                valid,
    output logic                busy
`ifdef SPI_RECEIVER_FRAME_ERROR_EN
    ,
    output logic                frame_error
`endif
);

    localparam int CW = $clog2(bitcount + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(bitcount);

    logic ss_i, ss_rise, ss_fall;
    logic sclk_i, sclk_rise, sclk_fall;
    logic sdi_i;
    logic sample, shift_en, complete;

    spi_rx_state_t      state_q, state_d;
    logic [bitcount-1:0] shift_q;
    logic [CW-1:0]       cnt_q;

    spi_input_synchronizer #(.stages(sync_stages), .invert(ss_polarity == SPI_SS_ACTIVE_LOW)) u_sync_ss (
        .clock(clock), .reset_n(reset_n), .din(ss), .dout(ss_i), .rise(ss_rise), .fall(ss_fall)
    );

    spi_input_synchronizer #(.stages(sync_stages), .invert(sclk_polarity)) u_sync_sclk (
        .clock(clock), .reset_n(reset_n), .din(sclk), .dout(sclk_i), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_input_synchronizer #(.stages(sync_stages), .invert(1'b0)) u_sync_sdi (
        .clock(clock), .reset_n(reset_n), .din(sdi), .dout(sdi_i), .rise(), .fall()
    );

    assign sample   = (sclk_phase == SPI_CPHA_LEADING) ? sclk_rise : sclk_fall;
    // Deselect always wins over a coincident sample strobe.
    assign shift_en = (state_q == ACTIVE) && sample && !ss_fall && (cnt_q != CNT_FULL);
    assign complete = (state_q == ACTIVE) && !ss_fall && (cnt_q == CNT_FULL);
    assign busy     = (state_q != IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ss_rise) state_d = ACTIVE;
            ACTIVE:  if (ss_fall) state_d = IDLE;
                     else if (cnt_q == CNT_FULL) state_d = FULL;
            FULL:    if (ss_fall) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
            data    <= '0;
            valid   <= 1'b0;
        end else begin
            valid <= complete;
            if (state_q == IDLE && ss_rise) begin
                shift_q <= '0;
                cnt_q   <= '0;
            end else if (shift_en) begin
                shift_q <= msb_first ? {shift_q[bitcount-2:0], sdi_i}
                                     : {sdi_i, shift_q[bitcount-1:1]};
                cnt_q   <= cnt_q + CW'(1);
            end
            if (complete) begin
                data <= shift_q;
            end
        end
    end

`ifdef SPI_RECEIVER_FRAME_ERROR_EN
    logic overflow_q;

    // Any sample strobe once the word is full marks the frame as long.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            if (state_q == IDLE && ss_rise) begin
                overflow_q <= 1'b0;
            end else if ((state_q == FULL || complete) && sample && !ss_fall) begin
                overflow_q <= 1'b1;
            end
            frame_error <= ss_fall && (((state_q == ACTIVE) && (cnt_q < CNT_FULL)) ||
                                       ((state_q == FULL) && overflow_q));
        end
    end
`endif

endmodule

// File: tb/tb_spi_receiver.sv
// tb/tb_spi_receiver.sv - scoreboard testbench for spi_receiver in mode 3 (16-bit MSB) and mode 0 (8-bit LSB)
module tb_spi_receiver;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        ss0, sclk0, sdi0;
    logic        ss1, sclk1, sdi1;
    logic [15:0] data0;
    logic [7:0]  data1;
    logic        valid0, valid1, busy0, busy1;
`ifdef SPI_RECEIVER_FRAME_ERROR_EN
    logic        fe0, fe1;
    int          fe0_count = 0;
`endif

    int tests = 0;
    int fails = 0;
    logic [63:0] q0[$];
    logic [63:0] q1[$];

    always #5 clock = ~clock;

    spi_receiver dut0 (
        .clock(clock), .reset_n(reset_n), .ss(ss0), .sclk(sclk0), .sdi(sdi0),
        .data(data0), .valid(valid0), .busy(busy0)
`ifdef SPI_RECEIVER_FRAME_ERROR_EN
        , .frame_error(fe0)
`endif
    );

    spi_receiver #(
        .bitcount(8), .ss_polarity(1'b0), .sclk_polarity(1'b0),
        .sclk_phase(1'b0), .msb_first(1'b0), .sync_stages(2)
    ) dut1 (
        .clock(clock), .reset_n(reset_n), .ss(ss1), .sclk(sclk1), .sdi(sdi1),
        .data(data1), .valid(valid1), .busy(busy1)
`ifdef SPI_RECEIVER_FRAME_ERROR_EN
        , .frame_error(fe1)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clock);
            if (valid0) begin
                if (q0.size() == 0) check("valid0 with empty queue", {63'b0, valid0}, 64'd0);
                else check("data0", {48'b0, data0}, q0.pop_front());
            end
            if (valid1) begin
                if (q1.size() == 0) check("valid1 with empty queue", {63'b0, valid1}, 64'd0);
                else check("data1", {56'b0, data1}, q1.pop_front());
            end
`ifdef SPI_RECEIVER_FRAME_ERROR_EN
            if (fe0) fe0_count++;
`endif
        end
    endtask

    // Mode 3: data changes on the falling (leading) edge, sampled on the rising edge.
    task automatic frame0(input logic [63:0] word, input int nbits, input bit deselect, input int gap);
        ss0 = 1'b0;
        repeat (2) @(negedge clock);
        check("busy0 before rise", {63'b0, busy0}, 64'd0);
        @(negedge clock);
        check("busy0 rise", {63'b0, busy0}, 64'd1);
        @(negedge clock);
        for (int i = 0; i < nbits; i++) begin
            sclk0 = 1'b0;
            sdi0  = word[nbits-1-i];
            repeat (4) @(negedge clock);
            sclk0 = 1'b1;
            repeat (4) @(negedge clock);
        end
        if (deselect) begin
            repeat (4) @(negedge clock);
            ss0 = 1'b1;
            repeat (2) @(negedge clock);
            check("busy0 before fall", {63'b0, busy0}, 64'd1);
            @(negedge clock);
            check("busy0 fall", {63'b0, busy0}, 64'd0);
            repeat (gap - 3) @(negedge clock);
        end
    endtask

    // Mode 0, LSB first: data set before the rising (leading) sample edge.
    task automatic frame1(input logic [7:0] word);
        ss1 = 1'b0;
        repeat (4) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            sdi1 = word[i];
            repeat (4) @(negedge clock);
            sclk1 = 1'b1;
            repeat (4) @(negedge clock);
            sclk1 = 1'b0;
        end
        repeat (4) @(negedge clock);
        ss1 = 1'b1;
        repeat (8) @(negedge clock);
    endtask

    initial begin
        reset_n = 1'b0;
        ss0 = 1'b1; sclk0 = 1'b1; sdi0 = 1'b0;
        ss1 = 1'b1; sclk1 = 1'b0; sdi1 = 1'b0;
        fork
            monitor();
        join_none
        repeat (3) @(negedge clock);
        check("reset data0", {48'b0, data0}, 64'd0);
        check("reset valid0", {63'b0, valid0}, 64'd0);
        check("reset busy0", {63'b0, busy0}, 64'd0);
        check("reset data1", {56'b0, data1}, 64'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);

        q0.push_back(64'hA5C3);
        frame0(64'hA5C3, 16, 1'b1, 8);

        q1.push_back(64'h01);
        frame1(8'h01);
        q1.push_back(64'h96);
        frame1(8'h96);

        q0.push_back(64'h1234);
        frame0(64'h1234, 16, 1'b1, 8);
        frame0(64'h0155, 9, 1'b1, 8);
        check("data0 held after short frame", {48'b0, data0}, 64'h1234);

        q0.push_back(64'hBEEF);
        frame0((64'hBEEF << 2) | 64'h3, 18, 1'b1, 8);

        frame0(64'h15, 5, 1'b0, 8);
        reset_n = 1'b0;
        ss0 = 1'b1;
        sclk0 = 1'b1;
        @(negedge clock);
        check("mid-frame reset data0", {48'b0, data0}, 64'd0);
        check("mid-frame reset valid0", {63'b0, valid0}, 64'd0);
        check("mid-frame reset busy0", {63'b0, busy0}, 64'd0);
`ifdef SPI_RECEIVER_FRAME_ERROR_EN
        check("mid-frame reset frame_error", {63'b0, fe0}, 64'd0);
`endif
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);
        q0.push_back(64'h0F0F);
        frame0(64'h0F0F, 16, 1'b1, 8);

        q0.push_back(64'h1111);
        frame0(64'h1111, 16, 1'b1, 3);
        q0.push_back(64'h2222);
        frame0(64'h2222, 16, 1'b1, 8);

        repeat (10) @(negedge clock);
        check("dut0 words outstanding", 64'(q0.size()), 64'd0);
        check("dut1 words outstanding", 64'(q1.size()), 64'd0);
`ifdef SPI_RECEIVER_FRAME_ERROR_EN
        check("frame_error pulses", 64'(fe0_count), 64'd2);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
